fb_arbiter: RTL
===============

Name: fb_arbiter

Overview:
- Shares the single-port framebuffer memory between two requesters: the display scanout reader and the draw engine, which reads and writes.
- Scanout has priority by default. A bounded-wait counter guarantees the draw engine forward progress.
- Tags each issued read and routes the memory's 1-cycle-latency read data back to the correct requester.
- Sits between the VGA timing/scanout logic and the draw engine on one side, and the framebuffer memory on the other.

Parameters:
- ADDR_WIDTH, 19, framebuffer word address width.
- DATA_WIDTH, 24, pixel width (RGB888).
- MAX_DRW_WAIT, 4, maximum consecutive cycles a valid draw request loses to scanout before it is forced through; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- scan_req_valid  in  1  scanout read request
- scan_req_addr  in  ADDR_WIDTH  scanout read address
- scan_req_ready  out  1  scanout request accepted this cycle
- scan_rsp_valid  out  1  scanout read data valid
- scan_rsp_data  out  DATA_WIDTH  scanout read data
- drw_req_valid  in  1  draw request
- drw_req_we  in  1  1 = write, 0 = read
- drw_req_addr  in  ADDR_WIDTH  draw address
- drw_req_wdata  in  DATA_WIDTH  draw write data
- drw_req_ready  out  1  draw request accepted this cycle
- drw_rsp_valid  out  1  draw read data valid
- drw_rsp_data  out  DATA_WIDTH  draw read data
- mem_r_en  out  1  memory read enable
- mem_r_addr  out  ADDR_WIDTH  memory read address
- mem_w_en  out  1  memory write enable
- mem_w_addr  out  ADDR_WIDTH  memory write address
- mem_w_data  out  DATA_WIDTH  memory write data
- mem_r_data  in  DATA_WIDTH  memory read data, valid 1 cycle after r_en is sampled
- mem_r_valid  in  1  memory read data valid

Behaviour:
- Reset: all ready, rsp_valid, mem_r_en and mem_w_en are 0. Wait counter = 0 and pending tag = NONE.
- A reset arriving mid-transfer discards any in-flight read; no response is delivered afterwards.
- Arbitration (combinational from current requests plus registered counter):
  - If only one requester is valid, it is granted.
  - If both are valid, scan is granted unless wait_cnt == MAX_DRW_WAIT, in which case draw is granted.
- Exactly one grant per cycle at most. mem_r_en and mem_w_en are never high together, because the memory's write would otherwise suppress the read.
- The ready of the granted requester is 1 in that cycle; the loser's ready is 0.
- An accepted request (valid && ready) drives the mem_* outputs combinationally in the same cycle.
- A draw write drives mem_w_en/addr/data and returns no response.
- wait_cnt behaviour:
  - +1 each cycle drw_req_valid=1 and the draw request is not granted.
  - Cleared on a draw grant or when drw_req_valid=0.
  - Saturates at MAX_DRW_WAIT.
- Pending tag register captures the granted source (SCAN or DRW) on every accepted read, and NONE otherwise.
- Response routing in the cycle after acceptance:
  - scan_rsp_valid = mem_r_valid && tag==SCAN.
  - drw_rsp_valid = mem_r_valid && tag==DRW.
  - Both rsp_data outputs mirror mem_r_data.
- Latency: a read accepted in cycle N responds in cycle N+1. Throughput is 1 accept per cycle; back-to-back reads from alternating sources route correctly.
- No response backpressure: requesters must accept rsp_valid unconditionally.
- Read-after-write: a draw write in cycle N followed by any read of the same address in N+1 returns the new data.
- mem_r_valid while tag==NONE is ignored; neither rsp_valid is asserted.

Optional Feature:
- Macro: FB_ARBITER_STATS_EN.
- When defined, three 32-bit outputs are added:
  - stat_scan_grants: +1 per scan accept.
  - stat_drw_grants: +1 per draw accept.
  - stat_drw_forced: +1 per draw grant caused by wait_cnt==MAX_DRW_WAIT.
- The counters clear on rst and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fb_pkg holds:
  - FB_ADDR_W=19 and FB_DATA_W=24.
  - Typedef fb_src_e {SRC_NONE, SRC_SCAN, SRC_DRW}, 2 bits.
- One sub-module, fb_arb_prio: the wait counter plus grant logic, producing the scan and draw grants and a forced flag.

Test Plan:
- Reset, then scan_req_valid=1 at addr 0x00010 with mem[0x00010]=0xABCDEF → scan_req_ready=1 the same cycle; next cycle scan_rsp_valid=1, data 0xABCDEF; drw_rsp_valid=0.
- Draw write addr 0x00020 data 0x123456 in cycle N, draw read 0x00020 in N+1 → drw_rsp_valid in N+2 with 0x123456; mem_r_en=0 in cycle N.
- Both requesters valid continuously, MAX_DRW_WAIT=4 → scan wins 4 cycles, draw wins the 5th, and the pattern repeats; mem_r_en&&mem_w_en never 1.
- Alternating accepted reads scan@A, drw@B, scan@C → responses in the following cycles route to scan, drw, scan with the correct data, one per cycle.
- Scan read accepted in cycle N, rst asserted in N+1 → no scan_rsp_valid; all outputs 0 during reset; normal operation after release.
- With FB_ARBITER_STATS_EN, run the starvation scenario for 10 cycles → stat_scan_grants=8, stat_drw_grants=2, stat_drw_forced=2.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and default widths for the framebuffer arbiter slice.
package fb_pkg;

    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 24;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_SCAN = 2'd1,
        SRC_DRW  = 2'd2
    } fb_src_e;

endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of the scanout, draw and framebuffer-memory signals around fb_arbiter.
interface fb_arbiter_if #(
    parameter int ADDR_WIDTH = fb_pkg::FB_ADDR_W,
    parameter int DATA_WIDTH = fb_pkg::FB_DATA_W
);
    logic                  scan_req_valid;
    logic [ADDR_WIDTH-1:0] scan_req_addr;
    logic                  scan_req_ready;
    logic                  scan_rsp_valid;
    logic [DATA_WIDTH-1:0] scan_rsp_data;

    logic                  drw_req_valid;
    logic                  drw_req_we;
    logic [ADDR_WIDTH-1:0] drw_req_addr;
    logic [DATA_WIDTH-1:0] drw_req_wdata;
    logic                  drw_req_ready;
    logic                  drw_rsp_valid;
    logic [DATA_WIDTH-1:0] drw_rsp_data;

    logic                  mem_r_en;
    logic [ADDR_WIDTH-1:0] mem_r_addr;
    logic                  mem_w_en;
    logic [ADDR_WIDTH-1:0] mem_w_addr;
    logic [DATA_WIDTH-1:0] mem_w_data;
    logic [DATA_WIDTH-1:0] mem_r_data;
    logic                  mem_r_valid;

    modport slave (
        input  scan_req_valid, scan_req_addr,
        output scan_req_ready, scan_rsp_valid, scan_rsp_data,
        input  drw_req_valid, drw_req_we, drw_req_addr, drw_req_wdata,
        output drw_req_ready, drw_rsp_valid, drw_rsp_data,
        output mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data,
        input  mem_r_data, mem_r_valid
    );

    modport master (
        output scan_req_valid, scan_req_addr,
        input  scan_req_ready, scan_rsp_valid, scan_rsp_data,
        output drw_req_valid, drw_req_we, drw_req_addr, drw_req_wdata,
        input  drw_req_ready, drw_rsp_valid, drw_rsp_data,
        input  mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data,
        output mem_r_data, mem_r_valid
    );
endinterface

// File: rtl/fb_arb_prio.sv
// Scanout-first grant logic with a saturating wait counter that forces a
// starved draw request through after MAX_DRW_WAIT consecutive losses.
module fb_arb_prio #(
    parameter int MAX_DRW_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic scan_valid,
    input  logic drw_valid,
    output logic scan_grant,
    output logic drw_grant,
    output logic forced
);
    logic [7:0] wait_cnt;
    logic       at_max;

    assign at_max = (wait_cnt == 8'(MAX_DRW_WAIT));

    always_comb begin
        scan_grant = 1'b0;
        drw_grant  = 1'b0;
        forced     = 1'b0;
        if (!rst) begin
            if (drw_valid && (!scan_valid || at_max)) begin
                drw_grant = 1'b1;
                forced    = scan_valid;
            end else if (scan_valid) begin
                scan_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!drw_valid || drw_grant) begin
            wait_cnt <= '0;
        end else if (!at_max) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout vs draw engine, tagged 1-cycle reads.
// Optional grant statistics outputs are enabled with FB_ARBITER_STATS_EN.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH   = FB_ADDR_W,
    parameter int DATA_WIDTH   = FB_DATA_W,
    parameter int MAX_DRW_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    fb_arbiter_if.slave bus
`ifdef FB_ARBITER_STATS_EN
    ,
    output logic [31:0] stat_scan_grants,
    output logic [31:0] stat_drw_grants,
    output logic [31:0] stat_drw_forced
`endif
);
    logic    scan_grant;
    logic    drw_grant;
    logic    forced;
    logic    drw_rd;
    logic    drw_wr;
    fb_src_e tag;

    fb_arb_prio #(.MAX_DRW_WAIT(MAX_DRW_WAIT)) u_prio (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (bus.scan_req_valid),
        .drw_valid  (bus.drw_req_valid),
        .scan_grant (scan_grant),
        .drw_grant  (drw_grant),
        .forced     (forced)
    );

    assign drw_rd = drw_grant && !bus.drw_req_we;
    assign drw_wr = drw_grant &&  bus.drw_req_we;

    assign bus.scan_req_ready = scan_grant;
    assign bus.drw_req_ready  = drw_grant;

    // At most one grant per cycle, so read and write enables are exclusive.
    assign bus.mem_r_en   = scan_grant || drw_rd;
    assign bus.mem_r_addr = scan_grant ? bus.scan_req_addr :
                            drw_rd     ? bus.drw_req_addr  : {ADDR_WIDTH{1'b0}};
    assign bus.mem_w_en   = drw_wr;
    assign bus.mem_w_addr = drw_wr ? bus.drw_req_addr  : {ADDR_WIDTH{1'b0}};
    assign bus.mem_w_data = drw_wr ? bus.drw_req_wdata : {DATA_WIDTH{1'b0}};

    always_ff @(posedge clk) begin
        if (rst) begin
            tag <= SRC_NONE;
        end else if (scan_grant) begin
            tag <= SRC_SCAN;
        end else if (drw_rd) begin
            tag <= SRC_DRW;
        end else begin
            tag <= SRC_NONE;
        end
    end

    // Gating with rst drops a read that was in flight when reset arrived.
    assign bus.scan_rsp_valid = !rst && bus.mem_r_valid && (tag == SRC_SCAN);
    assign bus.drw_rsp_valid  = !rst && bus.mem_r_valid && (tag == SRC_DRW);
    assign bus.scan_rsp_data  = bus.mem_r_data;
    assign bus.drw_rsp_data   = bus.mem_r_data;

`ifdef FB_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_scan_grants <= '0;
            stat_drw_grants  <= '0;
            stat_drw_forced  <= '0;
        end else begin
            if (scan_grant) stat_scan_grants <= stat_scan_grants + 32'd1;
            if (drw_grant)  stat_drw_grants  <= stat_drw_grants  + 32'd1;
            if (forced)     stat_drw_forced  <= stat_drw_forced  + 32'd1;
        end
    end
`endif
endmodule
